// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch / load-store memory port arbiter.
// The response-owner encoding is used by the top and exposed for debug.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_e;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int DATA_W_DEFAULT     = 32;
    localparam int MASK_W             = DATA_W_DEFAULT / 8;

    function automatic int mask_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational grant decision: data wins by default, fetch wins when the
// starvation limit is reached or when it is the only requester.
module mem_arb_priority (
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    input  logic starve_hit,
    output logic if_gnt,
    output logic d_gnt
);

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (en) begin
            if (if_req && (!d_req || starve_hit)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch and load/store, one access per cycle.
// Read data returns one cycle after grant, steered by the registered owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifReq,
    input  logic [ADDR_W-1:0]     ifAddr,
    output logic                  ifGnt,
    output logic                  ifRValid,
    output logic [DATA_W-1:0]     ifRData,
    input  logic                  dReq,
    input  logic [ADDR_W-1:0]     dAddr,
    input  logic [DATA_W-1:0]     dWData,
    input  logic [DATA_W/8-1:0]   dWMask,
    output logic                  dGnt,
    output logic                  dRValid,
    output logic [DATA_W-1:0]     dRData,
    output logic [ADDR_W-1:0]     memAddr,
    output logic                  memRstrb,
    output logic [DATA_W-1:0]     memWData,
    output logic [DATA_W/8-1:0]   memWMask,
    input  logic [DATA_W-1:0]     memRData,
    output logic [1:0]            dbg_resp_owner
);

    localparam int MW = mask_width(DATA_W);

    resp_owner_e         resp_owner_q, resp_owner_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                arb_en;
    logic                starve_hit;
    logic                if_gnt;
    logic                d_gnt;
    logic                mem_rstrb;
    logic [MW-1:0]       mem_wmask;

    assign arb_en     = !rst;
    assign starve_hit = (starve_cnt_q == 4'(STARVE_MAX));

    mem_arb_priority u_prio (
        .en         (arb_en),
        .if_req     (ifReq),
        .d_req      (dReq),
        .starve_hit (starve_hit),
        .if_gnt     (if_gnt),
        .d_gnt      (d_gnt)
    );

    // Idle cycles keep the last driven address so the memory bus stays quiet.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_rstrb    = 1'b0;
        mem_wmask    = '0;
        resp_owner_d = RESP_NONE;
        if (if_gnt) begin
            mem_addr_d   = ifAddr;
            mem_rstrb    = 1'b1;
            resp_owner_d = RESP_IF;
        end else if (d_gnt) begin
            mem_addr_d = dAddr;
            if (dWMask == '0) begin
                mem_rstrb    = 1'b1;
                resp_owner_d = RESP_D;
            end else begin
                mem_wmask = dWMask;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ifReq || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (d_gnt && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner_q <= RESP_NONE;
            starve_cnt_q <= 4'd0;
            mem_addr_q   <= '0;
        end else begin
            resp_owner_q <= resp_owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign ifGnt          = if_gnt;
    assign dGnt           = d_gnt;
    assign memAddr        = mem_addr_d;
    assign memRstrb       = mem_rstrb;
    assign memWMask       = mem_wmask;
    assign memWData       = dWData;
    assign ifRValid       = (resp_owner_q == RESP_IF);
    assign dRValid        = (resp_owner_q == RESP_D);
    assign ifRData        = memRData;
    assign dRData         = memRData;
    assign dbg_resp_owner = resp_owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, per-scenario tasks and a
// response scoreboard keyed by owner and data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk;
  logic          rst;
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic          ifGnt;
  logic          ifRValid;
  logic [DW-1:0] ifRData;
  logic          dReq;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWData;
  logic [MW-1:0] dWMask;
  logic          dGnt;
  logic          dRValid;
  logic [DW-1:0] dRData;
  logic [AW-1:0] memAddr;
  logic          memRstrb;
  logic [DW-1:0] memWData;
  logic [MW-1:0] memWMask;
  logic [DW-1:0] memRData;
  logic [1:0]    dbg_resp_owner;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] shadow [0:255];
  logic [DW-1:0] mem_rdata;
  logic [DW+1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRValid(ifRValid), .ifRData(ifRData),
    .dReq(dReq), .dAddr(dAddr), .dWData(dWData), .dWMask(dWMask), .dGnt(dGnt),
    .dRValid(dRValid), .dRData(dRData),
    .memAddr(memAddr), .memRstrb(memRstrb), .memWData(memWData), .memWMask(memWMask),
    .memRData(memRData), .dbg_resp_owner(dbg_resp_owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b ^ 8'h5A, 8'hC3, b, 8'h3C};
  endfunction

  // behavioural single-port memory, one-cycle read latency
  assign memRData = mem_rdata;
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = pattern(i);
    forever begin
      @(posedge clk);
      if (memRstrb) mem_rdata <= mem[memAddr[9:2]];
      for (int b = 0; b < MW; b++)
        if (memWMask[b]) mem[memAddr[9:2]][8*b +: 8] = memWData[8*b +: 8];
    end
  end

  // scoreboard: every read response is popped and checked against owner+data
  always @(negedge clk) begin
    if (!rst) begin
      if (ifRValid && dRValid) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_exclusive: ifRValid=%0b dRValid=%0b required one-hot", ifRValid, dRValid);
      end else if (ifRValid || dRValid) begin
        logic [DW+1:0] got;
        logic [DW+1:0] exp;
        got = ifRValid ? {2'(RESP_IF), ifRData} : {2'(RESP_D), dRData};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: owner=%0d data=%h with no outstanding read", got[DW+1:DW], got[DW-1:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp || dbg_resp_owner !== exp[DW+1:DW]) begin
            n_fail++;
            $display("FAIL resp: got owner=%0d data=%h dbg=%0d, required owner=%0d data=%h",
                     got[DW+1:DW], got[DW-1:0], dbg_resp_owner, exp[DW+1:DW], exp[DW-1:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drive_fetch(input logic [AW-1:0] a);
    @(negedge clk);
    ifReq  = 1'b1;
    ifAddr = a;
    #1;
  endtask

  task automatic drive_data(input logic [AW-1:0] a, input logic [DW-1:0] w, input logic [MW-1:0] m);
    @(negedge clk);
    dReq   = 1'b1;
    dAddr  = a;
    dWData = w;
    dWMask = m;
    #1;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    ifReq = 1'b0;
    dReq  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({ifRValid, dRValid, memRstrb, memWMask, ifGnt, dGnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valids=%b%b rstrb=%b wmask=%b gnt=%b%b required all 0",
               ifRValid, dRValid, memRstrb, memWMask, ifGnt, dGnt);
    end
    @(negedge clk);
    rst = 1'b0;
    // fetch granted, then reset lands while its response is showing
    drive_fetch(32'h10);
    n_checks++;
    if (ifGnt !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_gnt: ifGnt=%b required 1", ifGnt);
    end
    @(posedge clk);
    #1;
    dReq   = 1'b1;
    dWMask = 4'hF;
    n_checks++;
    if (ifRValid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_valid: ifRValid=%b required 1", ifRValid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ifRValid, dRValid, ifGnt, dGnt, memRstrb, memWMask, dbg_resp_owner} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valids=%b%b gnt=%b%b rstrb=%b wmask=%b owner=%0d required all 0",
               ifRValid, dRValid, ifGnt, dGnt, memRstrb, memWMask, dbg_resp_owner);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({ifGnt, dGnt, memRstrb, memWMask} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: gnt=%b%b rstrb=%b wmask=%b required 0", ifGnt, dGnt, memRstrb, memWMask);
    end
    @(negedge clk);
    ifReq  = 1'b0;
    dReq   = 1'b0;
    dWMask = '0;
    rst    = 1'b0;
  endtask

  task automatic test_fetch_only();
    drive_fetch(32'h0000_0010);
    n_checks++;
    if ({ifGnt, dGnt, memRstrb, memWMask} !== {1'b1, 1'b0, 1'b1, 4'h0} || memAddr !== 32'h10) begin
      n_fail++;
      $display("FAIL fetch_drive: gnt=%b%b rstrb=%b wmask=%b addr=%h required 1 0 1 0 00000010",
               ifGnt, dGnt, memRstrb, memWMask, memAddr);
    end
    exp_q.push_back({2'(RESP_IF), shadow[4]});
    end_cycle();
    @(negedge clk);
    n_checks++;
    if (ifRValid !== 1'b1 || dRValid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_valid: ifRValid=%b dRValid=%b required 1 0", ifRValid, dRValid);
    end
    // unaligned low bits go straight through
    drive_fetch(32'h0000_0013);
    n_checks++;
    if (memAddr !== 32'h13) begin
      n_fail++;
      $display("FAIL fetch_unaligned: addr=%h required 00000013", memAddr);
    end
    exp_q.push_back({2'(RESP_IF), shadow[4]});
    end_cycle();
    @(negedge clk);
    #1;
    n_checks++;
    if (memAddr !== 32'h13 || memRstrb !== 1'b0 || memWMask !== 4'h0) begin
      n_fail++;
      $display("FAIL idle_hold: addr=%h rstrb=%b wmask=%b required 00000013 0 0", memAddr, memRstrb, memWMask);
    end
  endtask

  task automatic test_store_load();
    drive_data(32'h100, 32'hAABB_CCDD, 4'b0011);
    n_checks++;
    if ({dGnt, ifGnt, memRstrb} !== 3'b100 || memWMask !== 4'b0011 ||
        memWData !== 32'hAABB_CCDD || memAddr !== 32'h100) begin
      n_fail++;
      $display("FAIL store_drive: gnt=%b%b rstrb=%b wmask=%b wdata=%h addr=%h required 10 0 0011 aabbccdd 00000100",
               dGnt, ifGnt, memRstrb, memWMask, memWData, memAddr);
    end
    shadow[64][15:0] = 16'hCCDD;
    end_cycle();
    @(negedge clk);
    n_checks++;
    if (dRValid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_no_resp: dRValid=%b required 0", dRValid);
    end
    drive_data(32'h100, '0, 4'h0);
    n_checks++;
    if (dGnt !== 1'b1 || memRstrb !== 1'b1 || memWMask !== 4'h0) begin
      n_fail++;
      $display("FAIL load_drive: dGnt=%b rstrb=%b wmask=%b required 1 1 0", dGnt, memRstrb, memWMask);
    end
    exp_q.push_back({2'(RESP_D), shadow[64]});
    end_cycle();
    @(negedge clk);
    n_checks++;
    if (dRValid !== 1'b1 || dRData !== shadow[64]) begin
      n_fail++;
      $display("FAIL load_data: dRValid=%b dRData=%h required 1 %h", dRValid, dRData, shadow[64]);
    end
  endtask

  task automatic test_contention();
    logic exp_if;
    dAddr  = 32'h40;
    dWMask = '0;
    ifAddr = 32'h20;
    // idx 13 drops ifReq for one cycle, which must clear the starvation count
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      dReq   = 1'b1;
      ifReq  = (i != 13);
      exp_if = (i == 4 || i == 9 || i == 18);
      #1;
      n_checks++;
      if ({ifGnt, dGnt} !== {exp_if, !exp_if}) begin
        n_fail++;
        $display("FAIL contention[%0d]: gnt if/d=%b%b required %b%b", i, ifGnt, dGnt, exp_if, !exp_if);
      end
      if (exp_if) exp_q.push_back({2'(RESP_IF), shadow[8]});
      else        exp_q.push_back({2'(RESP_D), shadow[16]});
    end
    end_cycle();
  endtask

  task automatic test_back_to_back();
    drive_data(32'h80, '0, 4'h0);
    n_checks++;
    if (dGnt !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_load_gnt: dGnt=%b required 1", dGnt);
    end
    exp_q.push_back({2'(RESP_D), shadow[32]});
    end_cycle();
    drive_fetch(32'h84);
    n_checks++;
    if (ifGnt !== 1'b1 || dRValid !== 1'b1 || dRData !== shadow[32]) begin
      n_fail++;
      $display("FAIL b2b_overlap: ifGnt=%b dRValid=%b dRData=%h required 1 1 %h", ifGnt, dRValid, dRData, shadow[32]);
    end
    exp_q.push_back({2'(RESP_IF), shadow[33]});
    end_cycle();
    @(negedge clk);
    n_checks++;
    if (ifRValid !== 1'b1 || dRValid !== 1'b0 || ifRData !== shadow[33]) begin
      n_fail++;
      $display("FAIL b2b_fetch_resp: ifRValid=%b dRValid=%b ifRData=%h required 1 0 %h", ifRValid, dRValid, ifRData, shadow[33]);
    end
  endtask

  task automatic test_random();
    int            kind;
    int            idx;
    logic [DW-1:0] w;
    logic [MW-1:0] m;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 63);
      w    = $urandom;
      m    = 4'($urandom_range(1, 15));
      if (kind == 0) begin
        @(negedge clk);
      end else if (kind == 1) begin
        drive_fetch(AW'(idx * 4));
        n_checks++;
        if (ifGnt !== 1'b1 || memRstrb !== 1'b1 || memAddr !== AW'(idx * 4)) begin
          n_fail++;
          $display("FAIL rand_fetch[%0d]: ifGnt=%b rstrb=%b addr=%h required 1 1 %h", i, ifGnt, memRstrb, memAddr, idx * 4);
        end
        exp_q.push_back({2'(RESP_IF), shadow[idx]});
        end_cycle();
      end else begin
        drive_data(AW'(idx * 4), w, (kind == 2) ? 4'h0 : m);
        n_checks++;
        if (dGnt !== 1'b1 || memRstrb !== (kind == 2) || memWMask !== ((kind == 2) ? 4'h0 : m)) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: dGnt=%b rstrb=%b wmask=%b kind=%0d", i, dGnt, memRstrb, memWMask, kind);
        end
        if (kind == 2) begin
          exp_q.push_back({2'(RESP_D), shadow[idx]});
        end else begin
          for (int b = 0; b < MW; b++)
            if (m[b]) shadow[idx][8*b +: 8] = w[8*b +: 8];
        end
        end_cycle();
      end
    end
  endtask

  task automatic test_reset_pending_load();
    drive_data(32'h100, '0, 4'h0);
    n_checks++;
    if (dGnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rpl_gnt: dGnt=%b required 1", dGnt);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dGnt !== 1'b0 || memRstrb !== 1'b0) begin
      n_fail++;
      $display("FAIL rpl_gnt_drop: dGnt=%b rstrb=%b required 0 0", dGnt, memRstrb);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dRValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rpl_in_reset: dRValid=%b required 0", dRValid);
    end
    @(negedge clk);
    dReq = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dRValid !== 1'b0 || ifRValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rpl_after_release: dRValid=%b ifRValid=%b required 0 0", dRValid, ifRValid);
    end
    drive_fetch(32'h10);
    n_checks++;
    if (ifGnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rpl_next_gnt: ifGnt=%b required 1", ifGnt);
    end
    exp_q.push_back({2'(RESP_IF), shadow[4]});
    end_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ifReq    = 1'b0;
    ifAddr   = '0;
    dReq     = 1'b0;
    dAddr    = '0;
    dWData   = '0;
    dWMask   = '0;
    for (int i = 0; i < 256; i++) shadow[i] = pattern(i);

    test_reset();
    test_fetch_only();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_pending_load();

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
